// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus between the MEM-stage controller and the
// data memory. The controller is the master; the memory is the slave.
interface mem_access_ctrl_if #(
    parameter int DMEM_ADDR_W = 32
);
    logic                   dmem_req_o;
    logic                   dmem_we_o;
    logic [DMEM_ADDR_W-1:0] dmem_addr_o;
    logic [31:0]            dmem_wdata_o;
    logic                   dmem_ack_i;
    logic [31:0]            dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_wdata_o,
        input  dmem_ack_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_wdata_o,
        output dmem_ack_i,
        output dmem_rdata_i
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller for a pipelined core.
// Issues one data-memory request per load/store, stalls the front of the
// pipeline until the memory acknowledges, and produces the MEM/WB register.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject word-misaligned
// accesses (no request, one-cycle misalign_o pulse, MEM/WB bubble).
module mem_access_ctrl #(
    parameter int DMEM_ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [31:0]       ALUResult_i,
    input  logic [31:0]       MemWriteData_i,
    input  logic [4:0]        RDaddr_i,
    mem_access_ctrl_if.master dmem,
    output logic              stall_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [31:0]       ReadData_o,
    output logic [31:0]       ALUResult_o,
    output logic [4:0]        RDaddr_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_stall;

    // Fields of the in-flight memory op, held while EX/MEM is frozen.
    logic        r_lat_regwrite;
    logic        r_lat_memtoreg;
    logic [31:0] r_lat_alu;
    logic [4:0]  r_lat_rd;
    logic [31:0] r_rdata_cap;

    // Request registers; they stay stable for the whole WAIT phase.
    logic                   r_dmem_req;
    logic                   r_dmem_we;
    logic [DMEM_ADDR_W-1:0] r_dmem_addr;
    logic [31:0]            r_dmem_wdata;

    // MEM/WB register.
    logic        r_regwrite;
    logic        r_memtoreg;
    logic [31:0] r_readdata;
    logic [31:0] r_alu;
    logic [4:0]  r_rd;

    logic w_mem_op;
    logic w_misaligned;
    logic w_issue;

    assign w_mem_op = MemRead_i | MemWrite_i;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = w_mem_op && (ALUResult_i[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_issue = w_mem_op & ~w_misaligned;

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and stall decode.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_stall      = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (dmem.dmem_ack_i) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is asserted.
    assign stall_o = w_stall & rst_i;

    // Request, latched-field and MEM/WB datapath.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_lat_regwrite <= 1'b0;
            r_lat_memtoreg <= 1'b0;
            r_lat_alu      <= '0;
            r_lat_rd       <= '0;
            r_rdata_cap    <= '0;
            r_dmem_req     <= 1'b0;
            r_dmem_we      <= 1'b0;
            r_dmem_addr    <= '0;
            r_dmem_wdata   <= '0;
            r_regwrite     <= 1'b0;
            r_memtoreg     <= 1'b0;
            r_readdata     <= '0;
            r_alu          <= '0;
            r_rd           <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_lat_regwrite <= RegWrite_i;
                        r_lat_memtoreg <= MemtoReg_i;
                        r_lat_alu      <= ALUResult_i;
                        r_lat_rd       <= RDaddr_i;
                        r_dmem_req     <= 1'b1;
                        // A simultaneous read+write request is a write.
                        r_dmem_we      <= MemWrite_i;
                        r_dmem_addr    <= ALUResult_i[DMEM_ADDR_W-1:0];
                        r_dmem_wdata   <= MemWriteData_i;
                        r_regwrite     <= 1'b0;
                        r_memtoreg     <= 1'b0;
                    end else if (w_misaligned) begin
                        r_regwrite <= 1'b0;
                        r_memtoreg <= 1'b0;
                    end else begin
                        r_regwrite <= RegWrite_i;
                        r_memtoreg <= MemtoReg_i;
                        r_alu      <= ALUResult_i;
                        r_rd       <= RDaddr_i;
                        r_readdata <= '0;
                    end
                end
                ST_WAIT: begin
                    r_regwrite <= 1'b0;
                    r_memtoreg <= 1'b0;
                    if (dmem.dmem_ack_i) begin
                        r_rdata_cap <= dmem.dmem_rdata_i;
                        r_dmem_req  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // EX/MEM still shows the same op this cycle; use the latch.
                    r_regwrite <= r_lat_regwrite;
                    r_memtoreg <= r_lat_memtoreg;
                    r_alu      <= r_lat_alu;
                    r_rd       <= r_lat_rd;
                    r_readdata <= r_dmem_we ? 32'd0 : r_rdata_cap;
                end
                default: begin
                    r_regwrite <= 1'b0;
                    r_memtoreg <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign;

    // One-cycle pulse for a rejected misaligned access.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= (r_state == ST_IDLE) && w_misaligned;
        end
    end

    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    assign dmem.dmem_req_o   = r_dmem_req;
    assign dmem.dmem_we_o    = r_dmem_we;
    assign dmem.dmem_addr_o  = r_dmem_addr;
    assign dmem.dmem_wdata_o = r_dmem_wdata;

    assign RegWrite_o  = r_regwrite;
    assign MemtoReg_o  = r_memtoreg;
    assign ReadData_o  = r_readdata;
    assign ALUResult_o = r_alu;
    assign RDaddr_o    = r_rd;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. A transaction-level model expands
// each instruction into its expected cycle timeline (stall, request, MEM/WB
// contents); one compare process checks the DUT against it every cycle, and
// literal expectations for the directed instructions pin the model.
module tb_mem_access_ctrl;

    localparam int AW = 32;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
    logic [31:0] ALUResult_i, MemWriteData_i;
    logic [4:0]  RDaddr_i;
    logic        stall_o, RegWrite_o, MemtoReg_o, misalign_o;
    logic [31:0] ReadData_o, ALUResult_o;
    logic [4:0]  RDaddr_o;

    mem_access_ctrl_if #(.DMEM_ADDR_W(AW)) dmem_bus ();

    mem_access_ctrl #(.DMEM_ADDR_W(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .RegWrite_i     (RegWrite_i),
        .MemtoReg_i     (MemtoReg_i),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .ALUResult_i    (ALUResult_i),
        .MemWriteData_i (MemWriteData_i),
        .RDaddr_i       (RDaddr_i),
        .dmem           (dmem_bus),
        .stall_o        (stall_o),
        .RegWrite_o     (RegWrite_o),
        .MemtoReg_o     (MemtoReg_o),
        .ReadData_o     (ReadData_o),
        .ALUResult_o    (ALUResult_o),
        .RDaddr_o       (RDaddr_o),
        .misalign_o     (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw, m2r, mr, mw;
        logic [31:0] alu, wd;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        instr_t      op;
        logic        rst, ack;
        logic [31:0] rdata;
        logic        chk;
        logic        e_stall, e_req, e_we, e_rw, e_m2r, e_mis;
        logic [31:0] e_addr, e_wdata, e_rdd, e_alu;
        logic [4:0]  e_rd;
        int          tag, snap;
    } cyc_t;

    cyc_t sched[$];

    // Model state: DUT-visible outputs as they stand during the next cycle.
    logic        m_valid = 1'b0;
    logic        m_req, m_we, m_rw, m_m2r, m_mis;
    logic [31:0] m_addr, m_wdata, m_rdd, m_alu;
    logic [4:0]  m_rd;
    int          last_tag = 0;
    int          pending_snap = 0;
    logic        force_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    int cur = 0;
    logic running = 1'b0;

    int          stall_cnt[16];
    int          req_cnt[16];
    logic [31:0] req_addr[16], req_wdata[16];
    logic        req_we[16];
    logic        sn_rw[16], sn_m2r[16], sn_mis[16], sn_req[16], sn_stall[16];
    logic [31:0] sn_rdd[16], sn_alu[16];
    logic [4:0]  sn_rd[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cur, act, exp);
        end
    endtask

    function automatic logic noise_ack();
        if (force_ack) begin
            force_ack = 1'b0;
            return 1'b1;
        end
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic push(input instr_t op, input logic rst, input logic ack,
                        input logic [31:0] rdata, input logic stall, input int tag);
        cyc_t c;
        c.op = op;  c.rst = rst;  c.ack = ack;  c.rdata = rdata;
        c.chk = m_valid;
        c.e_stall = stall;
        c.e_req = m_req;  c.e_we = m_we;  c.e_addr = m_addr;  c.e_wdata = m_wdata;
        c.e_rw = m_rw;  c.e_m2r = m_m2r;  c.e_rdd = m_rdd;  c.e_alu = m_alu;
        c.e_rd = m_rd;  c.e_mis = m_mis;
        c.tag = tag;  c.snap = pending_snap;
        pending_snap = 0;
        sched.push_back(c);
    endtask

    task automatic bubble();
        m_rw = 1'b0;  m_m2r = 1'b0;  m_mis = 1'b0;
    endtask

    task automatic add_reset(input instr_t op, input int tag);
        pending_snap = 0;
        push(op, 1'b0, noise_ack(), $urandom(), 1'b0, 0);
        m_valid = 1'b1;
        m_req = 0;  m_we = 0;  m_addr = 0;  m_wdata = 0;
        m_rw = 0;  m_m2r = 0;  m_rdd = 0;  m_alu = 0;  m_rd = 0;  m_mis = 0;
        last_tag = tag;
    endtask

    // One EX/MEM instruction: delay = WAIT cycles until ack (ack in the last).
    task automatic add_instr(input instr_t op, input int delay,
                             input logic [31:0] data, input int tag);
        logic is_mem, mis;
        is_mem = op.mr | op.mw;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = is_mem && (op.alu[1:0] != 2'b00);
`endif
        pending_snap = last_tag;
        last_tag = tag;
        if (!is_mem || mis) begin
            push(op, 1'b1, noise_ack(), $urandom(), 1'b0, tag);
            if (mis) begin
                bubble();
                m_mis = 1'b1;
            end else begin
                m_rw = op.rw;  m_m2r = op.m2r;  m_alu = op.alu;  m_rd = op.rd;
                m_rdd = 32'd0;  m_mis = 1'b0;
            end
        end else begin
            push(op, 1'b1, noise_ack(), $urandom(), 1'b1, tag);
            bubble();
            m_req = 1'b1;  m_we = op.mw;  m_addr = op.alu;  m_wdata = op.wd;
            for (int j = 1; j <= delay; j++) begin
                push(op, 1'b1, (j == delay), (j == delay) ? data : $urandom(), 1'b1, tag);
                bubble();
                if (j == delay) m_req = 1'b0;
            end
            push(op, 1'b1, noise_ack(), $urandom(), 1'b0, tag);
            m_rw = op.rw;  m_m2r = op.m2r;  m_alu = op.alu;  m_rd = op.rd;
            m_rdd = op.mw ? 32'd0 : data;  m_mis = 1'b0;
        end
    endtask

    // Memory op that is reset while waiting for its ack.
    task automatic add_abandon(input instr_t op, input int waits, input int tag);
        pending_snap = last_tag;
        last_tag = tag;
        push(op, 1'b1, noise_ack(), $urandom(), 1'b1, tag);
        bubble();
        m_req = 1'b1;  m_we = op.mw;  m_addr = op.alu;  m_wdata = op.wd;
        for (int j = 0; j < waits; j++) begin
            push(op, 1'b1, 1'b0, $urandom(), 1'b1, tag);
            bubble();
        end
        add_reset(op, 9);
    endtask

    function automatic instr_t mk(input logic rw, input logic m2r, input logic mr,
                                  input logic mw, input logic [31:0] alu,
                                  input logic [31:0] wd, input logic [4:0] rd);
        instr_t i;
        i.rw = rw;  i.m2r = m2r;  i.mr = mr;  i.mw = mw;
        i.alu = alu;  i.wd = wd;  i.rd = rd;
        return i;
    endfunction

    task automatic drive(input cyc_t c);
        rst_i          = c.rst;
        RegWrite_i     = c.op.rw;
        MemtoReg_i     = c.op.m2r;
        MemRead_i      = c.op.mr;
        MemWrite_i     = c.op.mw;
        ALUResult_i    = c.op.alu;
        MemWriteData_i = c.op.wd;
        RDaddr_i       = c.op.rd;
        dmem_bus.dmem_ack_i   = c.ack;
        dmem_bus.dmem_rdata_i = c.rdata;
    endtask

    // Compare process: DUT against the model every cycle, away from the edge.
    always @(negedge clk) begin
        if (running) begin
            cyc_t c;
            c = sched[cur];
            check("stall_o", {31'd0, stall_o}, {31'd0, c.e_stall});
            if (c.chk) begin
                check("dmem_req_o", {31'd0, dmem_bus.dmem_req_o}, {31'd0, c.e_req});
                check("dmem_we_o", {31'd0, dmem_bus.dmem_we_o}, {31'd0, c.e_we});
                check("dmem_addr_o", dmem_bus.dmem_addr_o, c.e_addr);
                check("dmem_wdata_o", dmem_bus.dmem_wdata_o, c.e_wdata);
                check("RegWrite_o", {31'd0, RegWrite_o}, {31'd0, c.e_rw});
                check("MemtoReg_o", {31'd0, MemtoReg_o}, {31'd0, c.e_m2r});
                check("ReadData_o", ReadData_o, c.e_rdd);
                check("ALUResult_o", ALUResult_o, c.e_alu);
                check("RDaddr_o", {27'd0, RDaddr_o}, {27'd0, c.e_rd});
                check("misalign_o", {31'd0, misalign_o}, {31'd0, c.e_mis});
            end
            if (stall_o === 1'b1) stall_cnt[c.tag]++;
            if (dmem_bus.dmem_req_o === 1'b1) begin
                req_cnt[c.tag]++;
                req_addr[c.tag]  = dmem_bus.dmem_addr_o;
                req_wdata[c.tag] = dmem_bus.dmem_wdata_o;
                req_we[c.tag]    = dmem_bus.dmem_we_o;
            end
            if (c.snap != 0) begin
                sn_rw[c.snap]    = RegWrite_o;
                sn_m2r[c.snap]   = MemtoReg_o;
                sn_rdd[c.snap]   = ReadData_o;
                sn_alu[c.snap]   = ALUResult_o;
                sn_rd[c.snap]    = RDaddr_o;
                sn_mis[c.snap]   = misalign_o;
                sn_req[c.snap]   = dmem_bus.dmem_req_o;
                sn_stall[c.snap] = stall_o;
            end
        end
    end

    initial begin
        instr_t op;
        int     kind;
        for (int t = 0; t < 16; t++) begin
            stall_cnt[t] = 0;  req_cnt[t] = 0;
            req_addr[t] = '0;  req_wdata[t] = '0;  req_we[t] = 1'b0;
            sn_rw[t] = 1'bx;  sn_m2r[t] = 1'bx;  sn_mis[t] = 1'bx;
            sn_req[t] = 1'bx;  sn_stall[t] = 1'bx;
            sn_rdd[t] = 'x;  sn_alu[t] = 'x;  sn_rd[t] = 'x;
        end

        // Reset with a load on the inputs: stall must stay low.
        op = mk(1, 1, 1, 0, 32'h0000_0040, 32'h0, 5'd2);
        for (int k = 0; k < 3; k++) add_reset(op, 8);

        // Directed: ALU op, slow load, fast store, word-misaligned load.
        add_instr(mk(1, 0, 0, 0, 32'h0000_0010, 32'h0, 5'd5), 0, 32'h0, 1);
        add_instr(mk(1, 1, 1, 0, 32'h0000_0100, 32'h1111_2222, 5'd7), 3, 32'hDEAD_BEEF, 2);
        add_instr(mk(0, 0, 0, 1, 32'h0000_0204, 32'hCAFE_F00D, 5'd0), 1, 32'h5555_AAAA, 3);
        add_instr(mk(1, 1, 1, 0, 32'h0000_0102, 32'h0, 5'd9), 2, 32'h1234_5678, 4);
        add_instr(mk(0, 0, 0, 0, 32'h0000_0000, 32'h0, 5'd0), 0, 32'h0, 5);

        // Randomized instruction stream.
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 9);
            op.rw  = $urandom_range(0, 1);
            op.m2r = $urandom_range(0, 1);
            op.mr  = (kind >= 4 && kind <= 6) || (kind == 9);
            op.mw  = (kind >= 7);
            op.wd  = $urandom();
            op.rd  = 5'($urandom_range(0, 31));
            if (op.mr || op.mw) begin
                op.alu = $urandom() & 32'hFFFF_FFFC;
                if ($urandom_range(0, 4) == 0) op.alu = op.alu | 32'($urandom_range(1, 3));
            end else begin
                op.alu = $urandom();
            end
            add_instr(op, $urandom_range(1, 4), $urandom(), 0);
        end

        // Reset while waiting; the ack arrives on the first cycle after reset.
        add_abandon(mk(1, 1, 1, 0, 32'h0000_0300, 32'h0, 5'd4), 2, 6);
        force_ack = 1'b1;
        add_instr(mk(1, 0, 0, 0, 32'h0000_0055, 32'h0, 5'd3), 0, 32'h0, 10);
        add_instr(mk(0, 0, 0, 0, 32'h0000_0000, 32'h0, 5'd0), 0, 32'h0, 0);

        rst_i = 1'b0;
        RegWrite_i = 0;  MemtoReg_i = 0;  MemRead_i = 0;  MemWrite_i = 0;
        ALUResult_i = 0;  MemWriteData_i = 0;  RDaddr_i = 0;
        dmem_bus.dmem_ack_i = 1'b0;
        dmem_bus.dmem_rdata_i = 32'd0;

        @(posedge clk);
        #1;
        for (int i = 0; i < sched.size(); i++) begin
            drive(sched[i]);
            cur = i;
            running = 1'b1;
            @(negedge clk);
            #1;
            @(posedge clk);
            #1;
        end
        running = 1'b0;

        // Literal expectations for the directed instructions.
        check("reset RegWrite_o", {31'd0, sn_rw[8]}, 32'd0);
        check("reset ALUResult_o", sn_alu[8], 32'd0);
        check("reset dmem_req_o", {31'd0, sn_req[8]}, 32'd0);
        check("alu stall cycles", stall_cnt[1], 32'd0);
        check("alu RegWrite_o", {31'd0, sn_rw[1]}, 32'd1);
        check("alu ALUResult_o", sn_alu[1], 32'h0000_0010);
        check("alu RDaddr_o", {27'd0, sn_rd[1]}, 32'd5);
        check("load req cycles", req_cnt[2], 32'd3);
        check("load stall cycles", stall_cnt[2], 32'd4);
        check("load we", {31'd0, req_we[2]}, 32'd0);
        check("load addr", req_addr[2], 32'h0000_0100);
        check("load RegWrite_o", {31'd0, sn_rw[2]}, 32'd1);
        check("load MemtoReg_o", {31'd0, sn_m2r[2]}, 32'd1);
        check("load ReadData_o", sn_rdd[2], 32'hDEAD_BEEF);
        check("load RDaddr_o", {27'd0, sn_rd[2]}, 32'd7);
        check("store req cycles", req_cnt[3], 32'd1);
        check("store stall cycles", stall_cnt[3], 32'd2);
        check("store we", {31'd0, req_we[3]}, 32'd1);
        check("store addr", req_addr[3], 32'h0000_0204);
        check("store wdata", req_wdata[3], 32'hCAFE_F00D);
        check("store RegWrite_o", {31'd0, sn_rw[3]}, 32'd0);
        check("store ReadData_o", sn_rdd[3], 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("misaligned req cycles", req_cnt[4], 32'd0);
        check("misaligned stall cycles", stall_cnt[4], 32'd0);
        check("misaligned misalign_o", {31'd0, sn_mis[4]}, 32'd1);
        check("misaligned RegWrite_o", {31'd0, sn_rw[4]}, 32'd0);
        check("misalign pulse width", {31'd0, sn_mis[5]}, 32'd0);
`else
        check("misaligned req cycles", req_cnt[4], 32'd2);
        check("misaligned addr", req_addr[4], 32'h0000_0102);
        check("misaligned misalign_o", {31'd0, sn_mis[4]}, 32'd0);
        check("misaligned ReadData_o", sn_rdd[4], 32'h1234_5678);
`endif
        check("abandon dmem_req_o", {31'd0, sn_req[9]}, 32'd0);
        check("abandon stall_o", {31'd0, sn_stall[9]}, 32'd0);
        check("abandon RegWrite_o", {31'd0, sn_rw[9]}, 32'd0);
        check("abandon ALUResult_o", sn_alu[9], 32'd0);
        check("after abandon RegWrite_o", {31'd0, sn_rw[10]}, 32'd1);
        check("after abandon ALUResult_o", sn_alu[10], 32'h0000_0055);
        check("after abandon RDaddr_o", {27'd0, sn_rd[10]}, 32'd3);
        check("after abandon ReadData_o", sn_rdd[10], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
